vga_layer_mixer: RTL and testbench
==================================

# vga_layer_mixer

Parametrised pixel compositor for the 1024x768@60 (65 MHz) game pipeline. It takes the timing bundle plus NUM_LAYERS colour layers (start/game-over screens, figures, platforms, background) and selects one pixel per cycle by fixed priority with colour-key transparency and per-layer enables. A frame-synchronous fade-to-black/fade-in controller scales the selected colour, and timing signals are delayed to match. It replaces the hard-wired two-input rgb mux at the end of the drawing chain.

## Interface
- NUM_LAYERS, 4, number of input layers; layer 0 has highest priority; range 2..8
- COLOR_W, 4, bits per colour channel; pixel width is 3*COLOR_W, packed {r,g,b}
- KEY_COLOR, 0, transparent colour value, 3*COLOR_W bits
- FADE_STEPS, 16, fade levels; power of two, 2..64
- FRAMES_PER_STEP, 2, frames per fade level change; 1..15

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  reset, asynchronous, active-low
- hcount_in, vcount_in  in  11 each  pixel position
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes
- layer_rgb  in  NUM_LAYERS x 3*COLOR_W  layer colours, aligned with the timing inputs
- layer_en  in  NUM_LAYERS  per-layer enable, level
- fade_out_req  in  1  single-cycle request to fade to black
- fade_in_req  in  1  single-cycle request to fade back to full brightness
- hcount_out, vcount_out  out  11 each  delayed position
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed strobes
- rgb_out  out  3*COLOR_W  final pixel
- fade_busy  out  1  high in FADE_OUT or FADE_IN
- fade_black  out  1  high in BLACK

## Operation
- Select stage: the winner is the lowest index i with layer_en[i]=1 and layer_rgb[i] != KEY_COLOR. If there is no winner, the result is KEY_COLOR.
- Fade stage: rgb_out channel = (channel * level) >> log2(FADE_STEPS). The product is COLOR_W+log2(FADE_STEPS)+1 bits wide, so there is no overflow. level = FADE_STEPS passes the colour unchanged.
- Blanking: rgb_out = 0 whenever the delayed hblnk or vblnk is high.
- Frame tick: rising edge of vsync_in, detected against a registered copy. A frame counter wraps at FRAMES_PER_STEP; a step fires on each wrap.
- FSM states: IDLE (level=FADE_STEPS), FADE_OUT, BLACK (level=0), FADE_IN.
  - IDLE + fade_out_req -> FADE_OUT; the frame counter clears.
  - FADE_OUT: level decrements by 1 per step; at level 0 -> BLACK.
  - BLACK + fade_in_req -> FADE_IN.
  - FADE_IN: level increments per step; at FADE_STEPS -> IDLE.
  - FADE_OUT + fade_in_req -> FADE_IN from the current level. FADE_IN + fade_out_req -> FADE_OUT. Neither reversal changes the level immediately.
  - Both requests in the same cycle: ignored, no state change.
  - fade_out_req in BLACK or FADE_OUT, and fade_in_req in IDLE or FADE_IN: ignored.
- The level changes only on a step, which is always at the start of vsync, so there is no mid-frame tearing.

## Timing
- Latency: 2 clk cycles, input to output, for every output except the fade flags.
  - Stage 1 registers the selected pixel and the timing bundle.
  - Stage 2 registers the faded pixel and the bundle.
- The level used in stage 2 is the registered level.
- fade_busy and fade_black are registered FSM decodes, valid 1 cycle after a state change.
- A request is accepted in the cycle it is high; the state changes on the next edge.
- Reset values:
  - FSM: state IDLE, level FADE_STEPS, frame counter 0, vsync edge register 0.
  - Outputs: all 0, including rgb_out, syncs, counts, fade_busy and fade_black.
- Reset asserted mid-fade returns the FSM to IDLE at full brightness immediately (asynchronous).
- Full fade duration: FADE_STEPS*FRAMES_PER_STEP frames, measured from the first tick after acceptance.

## Structure
- Package vga_mix_pkg:
  - fade_state_t enum {IDLE, FADE_OUT, BLACK, FADE_IN}
  - localparam-derived LEVEL_W = $clog2(FADE_STEPS)+1
  - pixel width helper
- Sub-module vga_fade_ctl holds the FSM, frame counter, vsync edge detect and level register. It outputs level, fade_busy and fade_black.
- vga_layer_mixer instantiates vga_fade_ctl and contains the priority select and the two pipeline stages.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- NUM_LAYERS=4, all enabled; layer0=KEY, layer1=12'hF00, layer2=12'h0F0 -> rgb_out=12'hF00 two cycles later, with timing delayed by 2.
- layer_en=4'b0100, layer2=12'h0F0, other layers non-key -> 12'h0F0. All layers KEY or disabled -> 12'h000.
- Pixel 12'hFFF with hblnk_in=1 -> rgb_out=0. The syncs still propagate with 2-cycle delay.
- fade_out_req with FADE_STEPS=16, FRAMES_PER_STEP=2 and constant 12'hFFF:
  - after 2 ticks -> 12'hEEE (15/16 scaling);
  - after 32 ticks -> fade_black=1, rgb_out=0;
  - fade_in_req -> back to 12'hFFF after 32 ticks, then fade_busy=0.
- Reversal and reset:
  - fade_in_req at level 10 during FADE_OUT -> level rises from 10;
  - both requests in one cycle -> no change;
  - rst low mid-fade -> IDLE, full brightness, outputs 0 during reset.

Source files
------------

// File: rtl/vga_mix_pkg.sv
// Shared types and width helpers for the VGA layer mixer and its fade controller.
package vga_mix_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

    function automatic int pix_w(input int color_w);
        return 3 * color_w;
    endfunction

    // One extra bit so the level can hold FADE_STEPS itself (full brightness).
    function automatic int level_w(input int fade_steps);
        return $clog2(fade_steps) + 1;
    endfunction

endpackage

// File: rtl/vga_fade_ctl.sv
// Frame-synchronous fade FSM: level steps once every FRAMES_PER_STEP vsync rising edges.
// Level and state update on the step edge; fade_busy/fade_black are registered decodes one cycle behind the state.
module vga_fade_ctl
    import vga_mix_pkg::*;
#(
    parameter int FADE_STEPS      = 16,
    parameter int FRAMES_PER_STEP = 2,
    parameter int LEVEL_W         = $clog2(FADE_STEPS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               fade_out_req,
    input  logic               fade_in_req,
    output logic [LEVEL_W-1:0] level,
    output logic               fade_busy,
    output logic               fade_black
);

    localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(FADE_STEPS);
    localparam logic [LEVEL_W-1:0] LVL_PRE  = LEVEL_W'(FADE_STEPS - 1);
    localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
    localparam logic [3:0]         FRM_LAST = 4'(FRAMES_PER_STEP - 1);

    fade_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [3:0]         frm_q, frm_d;
    logic               vs_q;
    logic               busy_q, black_q;

    logic tick, step, out_only, in_only;

    assign tick     = vsync_in & ~vs_q;
    assign step     = tick && (frm_q == FRM_LAST);
    assign out_only = fade_out_req & ~fade_in_req;
    assign in_only  = fade_in_req & ~fade_out_req;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        frm_d   = frm_q;
        // The frame counter only runs while fading, so every fade starts from a fresh count.
        if (tick) begin
            frm_d = step ? 4'd0 : frm_q + 4'd1;
        end
        case (state_q)
            IDLE: begin
                frm_d = 4'd0;
                if (out_only) state_d = FADE_OUT;
            end
            BLACK: begin
                frm_d = 4'd0;
                if (in_only) state_d = FADE_IN;
            end
            FADE_OUT: begin
                if (in_only) begin
                    state_d = FADE_IN;
                end else if (level_q == '0) begin
                    state_d = BLACK;
                end else if (step) begin
                    level_d = level_q - LVL_ONE;
                    if (level_q == LVL_ONE) state_d = BLACK;
                end
            end
            FADE_IN: begin
                if (out_only) begin
                    state_d = FADE_OUT;
                end else if (level_q == LVL_FULL) begin
                    state_d = IDLE;
                end else if (step) begin
                    level_d = level_q + LVL_ONE;
                    if (level_q == LVL_PRE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            level_q <= LVL_FULL;
            frm_q   <= 4'd0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            black_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            frm_q   <= frm_d;
            vs_q    <= vsync_in;
            busy_q  <= (state_q == FADE_OUT) || (state_q == FADE_IN);
            black_q <= (state_q == BLACK);
        end
    end

    assign level      = level_q;
    assign fade_busy  = busy_q;
    assign fade_black = black_q;

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority layer compositor with colour-key transparency, per-layer enable and frame-synchronous fade.
// Two-cycle latency on pixel and timing outputs; free-running pixel stream with no backpressure.
module vga_layer_mixer
    import vga_mix_pkg::*;
#(
    parameter int                   NUM_LAYERS      = 4,
    parameter int                   COLOR_W         = 4,
    parameter logic [3*COLOR_W-1:0] KEY_COLOR       = '0,
    parameter int                   FADE_STEPS      = 16,
    parameter int                   FRAMES_PER_STEP = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [10:0]                           hcount_in,
    input  logic [10:0]                           vcount_in,
    input  logic                                  hsync_in,
    input  logic                                  vsync_in,
    input  logic                                  hblnk_in,
    input  logic                                  vblnk_in,
    input  logic [NUM_LAYERS-1:0][3*COLOR_W-1:0]  layer_rgb,
    input  logic [NUM_LAYERS-1:0]                 layer_en,
    input  logic                                  fade_out_req,
    input  logic                                  fade_in_req,
    output logic [10:0]                           hcount_out,
    output logic [10:0]                           vcount_out,
    output logic                                  hsync_out,
    output logic                                  vsync_out,
    output logic                                  hblnk_out,
    output logic                                  vblnk_out,
    output logic [3*COLOR_W-1:0]                  rgb_out,
    output logic                                  fade_busy,
    output logic                                  fade_black
);

    localparam int PIX_W   = pix_w(COLOR_W);
    localparam int LEVEL_W = level_w(FADE_STEPS);
    localparam int FADE_SH = LEVEL_W - 1;
    localparam int PROD_W  = COLOR_W + LEVEL_W;

    if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("vga_layer_mixer: NUM_LAYERS must be 2..8");
    end
    if (FADE_STEPS < 2 || FADE_STEPS > 64 || (FADE_STEPS & (FADE_STEPS - 1)) != 0) begin : g_bad_steps
        $error("vga_layer_mixer: FADE_STEPS must be a power of two in 2..64");
    end
    if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 15) begin : g_bad_frames
        $error("vga_layer_mixer: FRAMES_PER_STEP must be 1..15");
    end

    vga_timing_t        tim_in, tim1_q, tim2_q;
    logic [PIX_W-1:0]   sel_pix, pix1_q, faded, rgb_q;
    logic [LEVEL_W-1:0] level;
    logic [PROD_W-1:0]  prod;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    vga_fade_ctl #(
        .FADE_STEPS      (FADE_STEPS),
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .LEVEL_W         (LEVEL_W)
    ) u_fade_ctl (
        .clk          (clk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .level        (level),
        .fade_busy    (fade_busy),
        .fade_black   (fade_black)
    );

    // Scan from lowest priority upward so the lowest visible index overwrites the rest.
    always_comb begin
        sel_pix = KEY_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && (layer_rgb[i] != KEY_COLOR)) sel_pix = layer_rgb[i];
        end
    end

    always_comb begin
        faded = '0;
        prod  = '0;
        for (int c = 0; c < 3; c++) begin
            prod = PROD_W'(pix1_q[c*COLOR_W +: COLOR_W]) * PROD_W'(level);
            faded[c*COLOR_W +: COLOR_W] = COLOR_W'(prod >> FADE_SH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tim1_q <= '0;
            tim2_q <= '0;
            pix1_q <= '0;
            rgb_q  <= '0;
        end else begin
            tim1_q <= tim_in;
            pix1_q <= sel_pix;
            tim2_q <= tim1_q;
            rgb_q  <= (tim1_q.hblnk || tim1_q.vblnk) ? '0 : faded;
        end
    end

    assign hcount_out = tim2_q.hcount;
    assign vcount_out = tim2_q.vcount;
    assign hsync_out  = tim2_q.hsync;
    assign vsync_out  = tim2_q.vsync;
    assign hblnk_out  = tim2_q.hblnk;
    assign vblnk_out  = tim2_q.vblnk;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: priority/key select, blanking, 2-cycle latency, fade sequencing and reset.
module tb_vga_layer_mixer;

    logic             clk = 1'b0;
    logic             rst;
    logic [10:0]      hcount_in, vcount_in;
    logic             hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [3:0][11:0] layer_rgb;
    logic [3:0]       layer_en;
    logic             fade_out_req, fade_in_req;
    logic [10:0]      hcount_out, vcount_out;
    logic             hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]      rgb_out;
    logic             fade_busy, fade_black;

    int n_chk  = 0;
    int n_fail = 0;

    vga_layer_mixer #(
        .NUM_LAYERS      (4),
        .COLOR_W         (4),
        .KEY_COLOR       (12'h000),
        .FADE_STEPS      (16),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .hblnk_in     (hblnk_in),
        .vblnk_in     (vblnk_in),
        .layer_rgb    (layer_rgb),
        .layer_en     (layer_en),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .hblnk_out    (hblnk_out),
        .vblnk_out    (vblnk_out),
        .rgb_out      (rgb_out),
        .fade_busy    (fade_busy),
        .fade_black   (fade_black)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            vsync_in = 1'b1;
            step();
            vsync_in = 1'b0;
            step();
        end
        step();
        step();
    endtask

    task automatic pulse(input logic out_r, input logic in_r);
        fade_out_req = out_r;
        fade_in_req  = in_r;
        step();
        fade_out_req = 1'b0;
        fade_in_req  = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        hcount_in    = 11'd5;
        vcount_in    = 11'd6;
        hsync_in     = 1'b1;
        vsync_in     = 1'b0;
        hblnk_in     = 1'b0;
        vblnk_in     = 1'b0;
        layer_rgb    = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        layer_en     = 4'b1111;
        fade_out_req = 1'b0;
        fade_in_req  = 1'b0;
        step();
        step();
        chk("reset_rgb", rgb_out, 12'h000);
        chk("reset_hcount", hcount_out, 11'd0);
        chk("reset_hsync", hsync_out, 1'b0);
        chk("reset_busy", fade_busy, 1'b0);
        chk("reset_black", fade_black, 1'b0);

        rst = 1'b1;
        // Vector A then B back to back to pin the latency at exactly two cycles.
        hcount_in = 11'd100; vcount_in = 11'd200; hsync_in = 1'b1;
        layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
        layer_en  = 4'b1111;
        step();
        hcount_in = 11'd101; vcount_in = 11'd201; hsync_in = 1'b0;
        layer_rgb = {12'h333, 12'h0F0, 12'h222, 12'h111};
        layer_en  = 4'b0100;
        step();
        chk("keyed_l0_rgb", rgb_out, 12'hF00);
        chk("keyed_l0_hcount", hcount_out, 11'd100);
        chk("keyed_l0_vcount", vcount_out, 11'd200);
        chk("keyed_l0_hsync", hsync_out, 1'b1);
        step();
        chk("only_l2_en_rgb", rgb_out, 12'h0F0);
        chk("only_l2_en_hcount", hcount_out, 11'd101);
        chk("only_l2_en_hsync", hsync_out, 1'b0);

        layer_rgb = {12'h000, 12'h000, 12'h000, 12'h000}; layer_en = 4'b1111;
        step(); step();
        chk("all_key", rgb_out, 12'h000);

        layer_rgb = {12'h456, 12'h789, 12'hABC, 12'hDEF}; layer_en = 4'b0000;
        step(); step();
        chk("all_disabled", rgb_out, 12'h000);

        layer_rgb = {12'h123, 12'h777, 12'h000, 12'hFFF}; layer_en = 4'b1010;
        step(); step();
        chk("mixed_en_key", rgb_out, 12'h123);

        layer_rgb = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}; layer_en = 4'b0001;
        hblnk_in = 1'b1; hsync_in = 1'b1; hcount_in = 11'd1100;
        step(); step();
        chk("hblnk_rgb", rgb_out, 12'h000);
        chk("hblnk_hsync", hsync_out, 1'b1);
        chk("hblnk_flag", hblnk_out, 1'b1);
        chk("hblnk_hcount", hcount_out, 11'd1100);

        hblnk_in = 1'b0; vblnk_in = 1'b1; hsync_in = 1'b0;
        step(); step();
        chk("vblnk_rgb", rgb_out, 12'h000);
        chk("vblnk_flag", vblnk_out, 1'b1);

        vblnk_in = 1'b0;
        step(); step();
        chk("idle_full", rgb_out, 12'hFFF);

        fade_in_req = 1'b1;
        step();
        fade_in_req = 1'b0;
        frame_ticks(2);
        chk("in_req_in_idle_ignored", rgb_out, 12'hFFF);
        chk("in_req_in_idle_busy", fade_busy, 1'b0);

        pulse(1'b1, 1'b0);
        step();
        chk("fade_out_busy", fade_busy, 1'b1);
        chk("fade_out_start", rgb_out, 12'hFFF);
        frame_ticks(2);
        chk("fade_out_lvl15", rgb_out, 12'hEEE);
        frame_ticks(6);
        chk("fade_out_lvl12", rgb_out, 12'hBBB);
        frame_ticks(24);
        chk("black_flag", fade_black, 1'b1);
        chk("black_busy", fade_busy, 1'b0);
        chk("black_rgb", rgb_out, 12'h000);

        pulse(1'b1, 1'b0);
        frame_ticks(2);
        chk("out_req_in_black_ignored", fade_black, 1'b1);

        pulse(1'b0, 1'b1);
        frame_ticks(4);
        chk("fade_in_lvl2", rgb_out, 12'h111);
        chk("fade_in_busy", fade_busy, 1'b1);
        frame_ticks(28);
        chk("fade_in_done_rgb", rgb_out, 12'hFFF);
        chk("fade_in_done_busy", fade_busy, 1'b0);
        chk("fade_in_done_black", fade_black, 1'b0);

        pulse(1'b1, 1'b0);
        frame_ticks(12);
        chk("reversal_lvl10", rgb_out, 12'h999);
        pulse(1'b0, 1'b1);
        step();
        chk("reversal_no_jump", rgb_out, 12'h999);
        frame_ticks(2);
        chk("reversal_lvl11", rgb_out, 12'hAAA);

        pulse(1'b1, 1'b1);
        frame_ticks(2);
        chk("both_req_ignored", rgb_out, 12'hBBB);
        chk("both_req_busy", fade_busy, 1'b1);

        rst = 1'b0;
        #1;
        chk("async_reset_rgb", rgb_out, 12'h000);
        chk("async_reset_busy", fade_busy, 1'b0);
        step();
        chk("in_reset_hcount", hcount_out, 11'd0);
        rst = 1'b1;
        step(); step();
        chk("post_reset_full", rgb_out, 12'hFFF);
        frame_ticks(2);
        chk("post_reset_idle", rgb_out, 12'hFFF);
        chk("post_reset_not_busy", fade_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
